// File: rtl/sha256_host_if.sv
`default_nettype none
// ============================================================================
// Module   : sha256_host_if
// Purpose  : Packs a word stream into a 256-bit message for the SHA-256 core
//            and streams the returned digest back out MSW first.
// Revision : 1.0
// ============================================================================
module sha256_host_if #(
  parameter int WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              word_v_i,
  input  logic [WORD_W-1:0] word_i,
  output logic              word_ready_o,
  output logic              core_v_o,
  output logic [255:0]      core_msg_o,
  input  logic              core_ready_i,
  input  logic              core_v_i,
  input  logic [255:0]      core_digest_i,
  output logic              core_yumi_o,
  output logic              out_v_o,
  output logic [WORD_W-1:0] out_word_o,
  input  logic              out_yumi_i,
  output logic              busy_o
);

  localparam int WORDS = 256 / WORD_W;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    eLoad    = 2'd0,
    eSend    = 2'd1,
    eWaitDig = 2'd2,
    eDrain   = 2'd3
  } state_t;

  state_t                       r_state;
  logic [CNT_W-1:0]             r_cnt;
  logic [WORDS-1:0][WORD_W-1:0] r_msg;
  logic [WORDS-1:0][WORD_W-1:0] r_dig;
  logic [CNT_W-1:0]             w_slot;

  // Word k lives in packed slot WORDS-1-k, so word 0 occupies the MSBs.
  assign w_slot = c_last_idx - r_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= eLoad;
      r_cnt   <= '0;
      r_msg   <= '0;
      r_dig   <= '0;
    end else begin
      case (r_state)
        eLoad: begin
          if (word_v_i) begin
            r_msg[w_slot] <= word_i;
            r_cnt         <= r_cnt + 1'b1;
            if (r_cnt == c_last_idx) begin
              r_state <= eSend;
            end
          end
        end
        eSend: begin
          if (core_ready_i) begin
            r_state <= eWaitDig;
          end
        end
        eWaitDig: begin
          if (core_v_i) begin
            r_dig   <= core_digest_i;
            r_state <= eDrain;
          end
        end
        eDrain: begin
          if (out_yumi_i) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == c_last_idx) begin
              r_state <= eLoad;
            end
          end
        end
        default: r_state <= eLoad;
      endcase
    end
  end

  assign word_ready_o = (r_state == eLoad);
  assign core_v_o     = (r_state == eSend);
  assign core_msg_o   = r_msg;
  // The only output with a combinational path from an input.
  assign core_yumi_o  = (r_state == eWaitDig) & core_v_i;
  assign out_v_o      = (r_state == eDrain);
  assign out_word_o   = r_dig[w_slot];
  assign busy_o       = (r_state != eLoad) | (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_sha256_host_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha256_host_if
// Purpose  : Self-checking bench for sha256_host_if against a message model.
// Revision : 1.0
// ============================================================================
module tb_sha256_host_if;

  localparam int WORD_W = 32;
  localparam int WORDS  = 256 / WORD_W;

  typedef logic [WORD_W-1:0] word_t;
  typedef word_t words_t [WORDS];

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b1;
  logic         word_v_i = 1'b0;
  word_t        word_i = '0;
  logic         word_ready_o;
  logic         core_v_o;
  logic [255:0] core_msg_o;
  logic         core_ready_i = 1'b0;
  logic         core_v_i = 1'b0;
  logic [255:0] core_digest_i = '0;
  logic         core_yumi_o;
  logic         out_v_o;
  word_t        out_word_o;
  logic         out_yumi_i = 1'b0;
  logic         busy_o;

  int n_pass  = 0;
  int n_total = 0;

  sha256_host_if #(.WORD_W(WORD_W)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .word_v_i      (word_v_i),
    .word_i        (word_i),
    .word_ready_o  (word_ready_o),
    .core_v_o      (core_v_o),
    .core_msg_o    (core_msg_o),
    .core_ready_i  (core_ready_i),
    .core_v_i      (core_v_i),
    .core_digest_i (core_digest_i),
    .core_yumi_o   (core_yumi_o),
    .out_v_o       (out_v_o),
    .out_word_o    (out_word_o),
    .out_yumi_i    (out_yumi_i),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: message is the word list concatenated first-word-high.
  function automatic logic [255:0] msg_of(input words_t w);
    logic [255:0] r = '0;
    for (int i = 0; i < WORDS; i++) r = (r << WORD_W) | 256'(w[i]);
    return r;
  endfunction

  function automatic word_t dig_word(input logic [255:0] d, input int k);
    logic [255:0] s = d >> (WORD_W * (WORDS - 1 - k));
    return s[WORD_W-1:0];
  endfunction

  function automatic logic [255:0] digest_of(input logic [255:0] m);
    return {m[127:0], m[255:128]} ^ {8{32'hC3A5_5A3C}};
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r = '0;
    for (int i = 0; i < 8; i++) r = (r << 32) | 256'($urandom);
    return r;
  endfunction

  task automatic rand_words(output words_t w);
    for (int i = 0; i < WORDS; i++) w[i] = $urandom;
  endtask

  // Offers the words (optionally with alternating gaps); returns at the
  // falling edge right after the last word is accepted.
  task automatic load(input words_t w, input bit gaps, output bit ok);
    int idx = 0;
    int cyc = 0;
    bit ph = 1'b0;
    ok = 1'b1;
    while (idx < WORDS) begin
      if (cyc > 200) begin ok = 1'b0; break; end
      word_v_i = gaps ? ph : 1'b1;
      ph = ~ph;
      word_i = word_v_i ? w[idx] : word_t'($urandom);
      if (word_v_i && word_ready_o) idx++;
      @(negedge clk_i);
      cyc++;
    end
    word_v_i = 1'b0;
    word_i   = $urandom;
  endtask

  task automatic core_take(input int stall_n, output logic [255:0] taken,
                           output int xfers, output bit stable);
    logic [255:0] first = core_msg_o;
    xfers = 0; stable = 1'b1; taken = '0;
    for (int i = 0; i < stall_n; i++) begin
      core_ready_i = 1'b0;
      if (core_v_o !== 1'b1 || core_msg_o !== first) stable = 1'b0;
      @(negedge clk_i);
    end
    for (int i = 0; i < 3; i++) begin
      core_ready_i = 1'b1;
      if (core_v_o === 1'b1) begin xfers++; taken = core_msg_o; end
      @(negedge clk_i);
    end
    core_ready_i = 1'b0;
  endtask

  // Core holds its valid one cycle past the yumi to show the yumi is a pulse.
  task automatic core_give(input logic [255:0] dig, input int delay, output int yumis);
    yumis = 0;
    for (int i = 0; i < delay; i++) begin
      core_v_i = 1'b0;
      #1 if (core_yumi_o === 1'b1) yumis++;
      @(negedge clk_i);
    end
    core_v_i = 1'b1;
    core_digest_i = dig;
    #1 if (core_yumi_o === 1'b1) yumis++;
    @(negedge clk_i);
    core_digest_i = ~dig;
    #1 if (core_yumi_o === 1'b1) yumis++;
    @(negedge clk_i);
    core_v_i = 1'b0;
  endtask

  task automatic drain(input int stall_at, input int stall_n, input int stop_after,
                       output word_t got[WORDS], output int n_got,
                       output bit held, output bit ok);
    int cyc = 0;
    int stalled = 0;
    word_t first = '0;
    n_got = 0; held = 1'b1; ok = 1'b1;
    for (int i = 0; i < WORDS; i++) got[i] = '0;
    while (n_got < stop_after) begin
      if (cyc > 200) begin ok = 1'b0; break; end
      out_yumi_i = 1'b0;
      if (out_v_o === 1'b1) begin
        if (n_got == stall_at && stalled < stall_n) begin
          if (stalled == 0) first = out_word_o;
          else if (out_word_o !== first) held = 1'b0;
          stalled++;
        end else begin
          if (stalled > 0 && n_got == stall_at && out_word_o !== first) held = 1'b0;
          out_yumi_i = 1'b1;
          got[n_got] = out_word_o;
          n_got++;
        end
      end
      @(negedge clk_i);
      cyc++;
    end
    out_yumi_i = 1'b0;
  endtask

  task automatic test_reset();
    n_total++; if (word_ready_o !== 1'b1) $display("FAIL rst_word_ready: got %b want 1", word_ready_o); else n_pass++;
    n_total++; if (core_v_o !== 1'b0) $display("FAIL rst_core_v: got %b want 0", core_v_o); else n_pass++;
    n_total++; if (core_yumi_o !== 1'b0) $display("FAIL rst_core_yumi: got %b want 0", core_yumi_o); else n_pass++;
    n_total++; if (out_v_o !== 1'b0) $display("FAIL rst_out_v: got %b want 0", out_v_o); else n_pass++;
    n_total++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy_o); else n_pass++;
    n_total++; if (core_msg_o !== 256'd0) $display("FAIL rst_core_msg: got %h want 0", core_msg_o); else n_pass++;
    n_total++; if (out_word_o !== 32'd0) $display("FAIL rst_out_word: got %h want 0", out_word_o); else n_pass++;
    reset_i = 1'b0;
    @(negedge clk_i);
    n_total++; if (word_ready_o !== 1'b1 || busy_o !== 1'b0) $display("FAIL rst_release: ready %b busy %b want 1 0", word_ready_o, busy_o); else n_pass++;
  endtask

  task automatic test_basic();
    words_t w;
    logic [255:0] taken;
    int xfers, yumis, n_got;
    bit stable, held, ok;
    word_t got[WORDS];
    logic [255:0] dig = 256'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3_A4A4A4A4_A5A5A5A5_A6A6A6A6_A7A7A7A7;
    for (int i = 0; i < WORDS; i++) w[i] = word_t'(i + 1);
    load(w, 1'b0, ok);
    n_total++; if (ok !== 1'b1) $display("FAIL basic_load_timeout: got %b want 1", ok); else n_pass++;
    n_total++; if (core_v_o !== 1'b1) $display("FAIL basic_core_v: got %b want 1", core_v_o); else n_pass++;
    n_total++; if (core_msg_o !== 256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008)
      $display("FAIL basic_core_msg: got %h want 0000000100000002...00000008", core_msg_o); else n_pass++;
    n_total++; if (busy_o !== 1'b1 || word_ready_o !== 1'b0) $display("FAIL basic_send_flags: busy %b ready %b want 1 0", busy_o, word_ready_o); else n_pass++;
    core_take(0, taken, xfers, stable);
    n_total++; if (xfers !== 1) $display("FAIL basic_xfers: got %0d want 1", xfers); else n_pass++;
    core_give(dig, 2, yumis);
    n_total++; if (yumis !== 1) $display("FAIL basic_yumi_pulses: got %0d want 1", yumis); else n_pass++;
    drain(-1, 0, WORDS, got, n_got, held, ok);
    n_total++; if (n_got !== WORDS) $display("FAIL basic_drain_count: got %0d want %0d", n_got, WORDS); else n_pass++;
    for (int k = 0; k < WORDS; k++) begin
      n_total++; if (got[k] !== dig_word(dig, k)) $display("FAIL basic_out_word%0d: got %h want %h", k, got[k], dig_word(dig, k)); else n_pass++;
    end
    n_total++; if (word_ready_o !== 1'b1 || busy_o !== 1'b0 || out_v_o !== 1'b0)
      $display("FAIL basic_return: ready %b busy %b out_v %b want 1 0 0", word_ready_o, busy_o, out_v_o); else n_pass++;
  endtask

  task automatic test_gaps();
    words_t w;
    logic [255:0] taken, dig;
    int xfers, yumis, n_got;
    bit stable, held, ok;
    word_t got[WORDS];
    rand_words(w);
    dig = rand256();
    core_v_i = 1'b1;
    core_digest_i = rand256();
    load(w, 1'b1, ok);
    #1;
    n_total++; if (core_yumi_o !== 1'b0) $display("FAIL gaps_yumi_outside_wait: got %b want 0", core_yumi_o); else n_pass++;
    core_v_i = 1'b0;
    n_total++; if (ok !== 1'b1 || core_msg_o !== msg_of(w)) $display("FAIL gaps_core_msg: got %h want %h", core_msg_o, msg_of(w)); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      word_v_i = 1'b1;
      word_i = $urandom;
      n_total++; if (word_ready_o !== 1'b0) $display("FAIL gaps_ready_in_send: got %b want 0", word_ready_o); else n_pass++;
      @(negedge clk_i);
    end
    core_take(0, taken, xfers, stable);
    n_total++; if (taken !== msg_of(w) || xfers !== 1) $display("FAIL gaps_taken: got %h x%0d want %h x1", taken, xfers, msg_of(w)); else n_pass++;
    n_total++; if (word_ready_o !== 1'b0 || busy_o !== 1'b1) $display("FAIL gaps_wait_flags: ready %b busy %b want 0 1", word_ready_o, busy_o); else n_pass++;
    core_give(dig, 1, yumis);
    word_v_i = 1'b0;
    drain(-1, 0, WORDS, got, n_got, held, ok);
    for (int k = 0; k < WORDS; k++) begin
      n_total++; if (got[k] !== dig_word(dig, k)) $display("FAIL gaps_out_word%0d: got %h want %h", k, got[k], dig_word(dig, k)); else n_pass++;
    end
    n_total++; if (busy_o !== 1'b0) $display("FAIL gaps_busy_end: got %b want 0", busy_o); else n_pass++;
  endtask

  task automatic test_backpressure();
    words_t w;
    logic [255:0] taken, dig;
    int xfers, yumis, n_got;
    bit stable, held, ok;
    word_t got[WORDS];
    rand_words(w);
    dig = rand256();
    load(w, 1'b0, ok);
    core_take(5, taken, xfers, stable);
    n_total++; if (stable !== 1'b1) $display("FAIL bp_hold: got stable=%b want 1", stable); else n_pass++;
    n_total++; if (xfers !== 1) $display("FAIL bp_xfers: got %0d want 1", xfers); else n_pass++;
    n_total++; if (taken !== msg_of(w)) $display("FAIL bp_taken: got %h want %h", taken, msg_of(w)); else n_pass++;
    core_give(dig, 20, yumis);
    n_total++; if (yumis !== 1) $display("FAIL bp_yumi_pulses: got %0d want 1", yumis); else n_pass++;
    drain(-1, 0, WORDS, got, n_got, held, ok);
    for (int k = 0; k < WORDS; k++) begin
      n_total++; if (got[k] !== dig_word(dig, k)) $display("FAIL bp_out_word%0d: got %h want %h", k, got[k], dig_word(dig, k)); else n_pass++;
    end
  endtask

  task automatic test_stalls();
    words_t w;
    logic [255:0] taken, dig;
    int xfers, yumis, n_got;
    bit stable, held, ok;
    word_t got[WORDS];
    rand_words(w);
    dig = rand256();
    load(w, 1'b0, ok);
    core_take(0, taken, xfers, stable);
    core_give(dig, 1, yumis);
    drain(3, 3, WORDS, got, n_got, held, ok);
    n_total++; if (held !== 1'b1) $display("FAIL stall_hold: got held=%b want 1", held); else n_pass++;
    n_total++; if (ok !== 1'b1 || n_got !== WORDS) $display("FAIL stall_count: got %0d want %0d", n_got, WORDS); else n_pass++;
    for (int k = 0; k < WORDS; k++) begin
      n_total++; if (got[k] !== dig_word(dig, k)) $display("FAIL stall_out_word%0d: got %h want %h", k, got[k], dig_word(dig, k)); else n_pass++;
    end
    n_total++; if (word_ready_o !== 1'b1) $display("FAIL stall_ready_after: got %b want 1", word_ready_o); else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    words_t w, w2;
    logic [255:0] taken, dig;
    int xfers, yumis, n_got;
    bit stable, held, ok;
    word_t got[WORDS];
    rand_words(w);
    rand_words(w2);
    dig = rand256();
    load(w, 1'b0, ok);
    core_take(0, taken, xfers, stable);
    core_give(dig, 1, yumis);
    drain(-1, 0, 3, got, n_got, held, ok);
    for (int k = 0; k < 3; k++) begin
      n_total++; if (got[k] !== dig_word(dig, k)) $display("FAIL rmd_pre_word%0d: got %h want %h", k, got[k], dig_word(dig, k)); else n_pass++;
    end
    reset_i = 1'b1;
    #1;
    n_total++; if (out_v_o !== 1'b0) $display("FAIL rmd_out_v: got %b want 0", out_v_o); else n_pass++;
    n_total++; if (word_ready_o !== 1'b1 || busy_o !== 1'b0) $display("FAIL rmd_flags: ready %b busy %b want 1 0", word_ready_o, busy_o); else n_pass++;
    n_total++; if (core_msg_o !== 256'd0 || out_word_o !== 32'd0) $display("FAIL rmd_cleared: msg %h word %h want 0 0", core_msg_o, out_word_o); else n_pass++;
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    n_total++; if (out_v_o !== 1'b0 || core_v_o !== 1'b0) $display("FAIL rmd_spurious: out_v %b core_v %b want 0 0", out_v_o, core_v_o); else n_pass++;
    load(w2, 1'b0, ok);
    n_total++; if (core_v_o !== 1'b1 || core_msg_o !== msg_of(w2)) $display("FAIL rmd_fresh_msg: got %h want %h", core_msg_o, msg_of(w2)); else n_pass++;
    core_take(0, taken, xfers, stable);
    core_give(dig, 1, yumis);
    drain(-1, 0, WORDS, got, n_got, held, ok);
    n_total++; if (got[0] !== dig_word(dig, 0) || got[WORDS-1] !== dig_word(dig, WORDS-1))
      $display("FAIL rmd_fresh_drain: got %h..%h want %h..%h", got[0], got[WORDS-1], dig_word(dig, 0), dig_word(dig, WORDS-1)); else n_pass++;
  endtask

  task automatic test_back_to_back();
    words_t m0, m1;
    word_t up[2*WORDS];
    word_t outs[2*WORDS];
    int acc_cyc[2*WORDS];
    int out_cyc[2*WORDS];
    logic [255:0] takes[2];
    logic [255:0] exp_msg[2];
    int idx = 0, n_out = 0, n_take = 0, cyc = 0;
    rand_words(m0);
    rand_words(m1);
    exp_msg[0] = msg_of(m0);
    exp_msg[1] = msg_of(m1);
    for (int i = 0; i < WORDS; i++) begin
      up[i] = m0[i];
      up[WORDS+i] = m1[i];
    end
    for (int i = 0; i < 2*WORDS; i++) begin acc_cyc[i] = -1; out_cyc[i] = -1; outs[i] = '0; end
    takes[0] = '0; takes[1] = '0;
    core_ready_i = 1'b1;
    core_v_i     = 1'b1;
    out_yumi_i   = 1'b1;
    while (n_out < 2*WORDS && cyc < 400) begin
      if (idx < 2*WORDS) begin
        word_v_i = 1'b1;
        word_i   = up[idx];
        if (word_ready_o === 1'b1) begin acc_cyc[idx] = cyc; idx++; end
      end else begin
        word_v_i = 1'b0;
      end
      if (core_v_o === 1'b1 && n_take < 2) begin
        takes[n_take] = core_msg_o;
        core_digest_i = digest_of(core_msg_o);
        n_take++;
      end
      if (out_v_o === 1'b1) begin outs[n_out] = out_word_o; out_cyc[n_out] = cyc; n_out++; end
      @(negedge clk_i);
      cyc++;
    end
    word_v_i = 1'b0; core_ready_i = 1'b0; core_v_i = 1'b0; out_yumi_i = 1'b0;
    n_total++; if (n_out !== 2*WORDS || n_take !== 2) $display("FAIL b2b_counts: outs %0d takes %0d want 16 2", n_out, n_take); else n_pass++;
    for (int j = 0; j < 2; j++) begin
      n_total++; if (takes[j] !== exp_msg[j]) $display("FAIL b2b_msg%0d: got %h want %h", j, takes[j], exp_msg[j]); else n_pass++;
      for (int k = 0; k < WORDS; k++) begin
        n_total++; if (outs[j*WORDS+k] !== dig_word(digest_of(exp_msg[j]), k))
          $display("FAIL b2b_out%0d_%0d: got %h want %h", j, k, outs[j*WORDS+k], dig_word(digest_of(exp_msg[j]), k)); else n_pass++;
      end
    end
    n_total++; if (acc_cyc[WORDS-1] !== WORDS-1) $display("FAIL b2b_first_load_rate: last word at cycle %0d want %0d", acc_cyc[WORDS-1], WORDS-1); else n_pass++;
    n_total++; if (acc_cyc[WORDS] !== out_cyc[WORDS-1] + 1)
      $display("FAIL b2b_second_start: accepted at %0d want %0d", acc_cyc[WORDS], out_cyc[WORDS-1] + 1); else n_pass++;
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    test_reset();
    test_basic();
    test_gaps();
    test_backpressure();
    test_stalls();
    test_reset_mid_drain();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/sha256_host_if.md
# sha256_host_if

Host-side adapter for the SHA-256 core: it drives the core's input handshake and consumes the core's output handshake. It assembles eight 32-bit words from an upstream word stream into one 256-bit message. It then presents that message to the core with a valid/ready handshake, takes the 256-bit digest back with a valid/yumi handshake, and streams the digest out as eight 32-bit words. The block sits between the FSB-facing word interface and the core, and processes one message at a time with no overlap.

## Interface
- WORD_W, 32, word width on the upstream and downstream streams; 256 must be a multiple of WORD_W; WORDS = 256/WORD_W (8 by default)
- clk_i  in  1  single clock; all state changes on its rising edge
- reset_i  in  1  asynchronous, active-high reset
- word_v_i  in  1  upstream word valid
- word_i  in  WORD_W  upstream message word
- word_ready_o  out  1  block can accept a word this cycle
- core_v_o  out  1  core_msg_o is valid and offered to the core
- core_msg_o  out  256  assembled message to the core
- core_ready_i  in  1  core accepts the message this cycle
- core_v_i  in  1  core digest valid
- core_digest_i  in  256  digest from the core
- core_yumi_o  out  1  block consumes core_digest_i this cycle
- out_v_o  out  1  out_word_o is valid
- out_word_o  out  WORD_W  digest word
- out_yumi_i  in  1  downstream consumes out_word_o this cycle
- busy_o  out  1  high in every state except eLoad, and also high in eLoad once at least one word is held

## Operation
- FSM states: eLoad, eSend, eWaitDig, eDrain. Reset state is eLoad.
- Word counter cnt_r is log2(WORDS) bits wide, resets to 0, and wraps modulo WORDS.
- **eLoad**
  - word_ready_o = 1.
  - A word is accepted when word_v_i & word_ready_o.
  - Word k (k = cnt_r) is written to msg_r[256-1-k*WORD_W -: WORD_W], so the first word lands in the MSBs.
  - cnt_r increments on each accepted word.
  - When word WORDS-1 is accepted, cnt_r wraps to 0 and the FSM moves to eSend.
- **eSend**
  - core_v_o = 1 and core_msg_o = msg_r, held stable until the transfer.
  - The transfer happens when core_v_o & core_ready_i; the FSM then moves to eWaitDig.
  - word_v_i is ignored in this state.
- **eWaitDig**
  - core_yumi_o = core_v_i. This is combinational and is the only combinational output.
  - On core_v_i, core_digest_i is latched into dig_r and the FSM moves to eDrain.
- **eDrain**
  - out_v_o = 1 and out_word_o = dig_r[256-1-cnt_r*WORD_W -: WORD_W], so the MSW goes out first.
  - cnt_r increments on out_yumi_i.
  - On the yumi for word WORDS-1, cnt_r wraps to 0 and the FSM moves to eLoad.
- Ignored inputs:
  - core_v_i outside eWaitDig: core_yumi_o stays 0.
  - core_ready_i outside eSend.
  - out_yumi_i while out_v_o = 0.
- Reset:
  - Values after reset: state = eLoad, cnt_r = 0, msg_r = 0, dig_r = 0.
  - Outputs after reset: word_ready_o = 1; core_v_o, core_yumi_o, out_v_o and busy_o = 0; core_msg_o and out_word_o = 0.
  - Reset asserted mid-operation discards all partial words and any digest immediately. No spurious handshake follows deassertion.

## Timing
- Every output except core_yumi_o is a function of registered state only.
- Load: WORDS accepted words, one per cycle at most. core_v_o rises the cycle after the last word is accepted.
- Send: minimum one cycle with core_v_o high. Back-pressure from core_ready_i = 0 holds core_v_o and core_msg_o unchanged.
- Capture: core_yumi_o is asserted in the same cycle that core_v_i is seen in eWaitDig. out_v_o rises the next cycle.
- Drain: at most one word per cycle. out_v_o and out_word_o are held while out_yumi_i = 0.
- Return to load: word_ready_o = 1 the cycle after the last drain yumi.
- Minimum cycles per message: WORDS + 1 + core latency + 1 + WORDS.

## Test plan
- **Basic flow.**
  - Stimulus: reset; send words 0x00000001..0x00000008 back-to-back.
  - Required: core_msg_o = 0x00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008 with core_v_o high the next cycle.
  - Stimulus: core returns 0xA0A0A0A0_..._A7A7A7A7.
  - Required: out_word_o sequence A0A0A0A0..A7A7A7A7, MSW first.
- **Upstream gaps and early input.**
  - Stimulus: word_v_i toggled 1,0,1,0…; words offered during eSend/eWaitDig.
  - Required: only the 8 eLoad words are captured; words offered in other states are ignored and word_ready_o = 0 there.
- **Core back-pressure.**
  - Stimulus: core_ready_i held 0 for 5 cycles.
  - Required: core_v_o = 1 with core_msg_o constant for all 5 cycles; exactly one transfer occurs.
  - Stimulus: core_v_i raised only after 20 cycles.
  - Required: core_yumi_o pulses for exactly 1 cycle.
- **Downstream stalls.**
  - Stimulus: out_yumi_i low for 3 cycles on word 4.
  - Required: out_word_o holds word 4 stable; all 8 words are delivered once, with no duplicates or skips; word_ready_o = 1 after the 8th yumi.
- **Reset mid-drain.**
  - Stimulus: assert reset_i after the 3rd word drained.
  - Required: out_v_o = 0 immediately; word_ready_o = 1; busy_o = 0.
  - Stimulus: a fresh 8-word message afterwards.
  - Required: the correct core_msg_o with no residual data.
- **Back-to-back messages.**
  - Stimulus: two full messages with upstream always valid.
  - Required: the second message's first word is accepted only after the first message's 8th digest word is consumed; the cnt_r wrap is correct both times.
